// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: opcodes, sequencer
// state encoding and default parameters.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b100000;

  localparam int TIMEOUT_DEF = 16;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_WAIT_MEM = 3'd1,
    ST_DRAIN    = 3'd2,
    ST_HALTED   = 3'd3,
    ST_ERROR    = 3'd4
  } state_e;

  // Instructions whose rt field is a source operand (LW writes rt instead).
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is
// read by the instruction in IF/ID.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic [5:0] id_opcode,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic       lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_rt == id_rs);
  assign rt_hit = (ex_rt == id_rt) && reads_rt(id_opcode);
  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign lu     = ex_memread && (ex_rt != 5'd0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 5-stage MIPS core: stall/bubble/flush decisions,
// debug halt/drain/resume, per-stage valid tracking and stall-cycle counting.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       id_opcode,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_flush,
  output logic             pipe_advance,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output state_e           dbg_state,
  output logic [3:0]       dbg_vld
);

  localparam int              WC_W    = $clog2(TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  state_e           state_q, state_d;
  logic             ret_drain_q, ret_drain_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]       vld_q, vld_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic lu;
  logic mem_stall;
  logic flow;
  logic drain_mode;
  logic ifid_write_eff;
  logic c_pc_write, c_ifid_write, c_ifid_flush, c_idex_bubble;
  logic c_exmem_flush, c_pipe_advance, c_halted;

  load_use_detect u_lu (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_opcode  (id_opcode),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .lu         (lu)
  );

  assign mem_stall      = mem_req && !dmem_ready;
  assign ifid_write_eff = c_ifid_write || c_ifid_flush;

  always_comb begin
    c_pc_write     = 1'b0;
    c_ifid_write   = 1'b0;
    c_ifid_flush   = 1'b0;
    c_idex_bubble  = 1'b0;
    c_exmem_flush  = 1'b0;
    c_pipe_advance = 1'b0;
    c_halted       = 1'b0;
    flow           = 1'b0;
    drain_mode     = 1'b0;
    state_d        = state_q;
    ret_drain_d    = ret_drain_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    vld_d          = vld_q;
    stall_cnt_d    = stall_cnt_q;

    // Freeze is the default; only cycles that reach "flow" drive the pipe.
    unique case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d     = ST_WAIT_MEM;
          ret_drain_d = 1'b0;
          wait_cnt_d  = WC_ONE;
        end else begin
          flow = 1'b1;
        end
      end
      ST_WAIT_MEM: begin
        if (!dmem_ready) begin
          if (wait_cnt_q == WC_LAST) begin
            state_d       = ST_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          flow       = 1'b1;
          drain_mode = ret_drain_q;
        end
      end
      ST_DRAIN: begin
        if (mem_stall) begin
          state_d     = ST_WAIT_MEM;
          ret_drain_d = 1'b1;
          wait_cnt_d  = WC_ONE;
        end else begin
          flow       = 1'b1;
          drain_mode = 1'b1;
        end
      end
      ST_HALTED: begin
        c_halted = 1'b1;
        if (resume) state_d = ST_RUN;
      end
      ST_ERROR: begin
        mem_timeout_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase

    if (flow) begin
      c_pipe_advance = 1'b1;
      if (mem_branch_taken) begin
        c_pc_write    = 1'b1;
        c_ifid_flush  = 1'b1;
        c_idex_bubble = 1'b1;
        c_exmem_flush = 1'b1;
      end else if (lu) begin
        c_idex_bubble = 1'b1;
      end else if (drain_mode) begin
        // IF/ID is loaded with a bubble so the ID instruction still moves on.
        c_ifid_write = 1'b1;
        c_ifid_flush = 1'b1;
      end else begin
        c_pc_write   = 1'b1;
        c_ifid_write = 1'b1;
      end
    end

    if (c_pipe_advance) begin
      vld_d[0] = c_ifid_flush ? 1'b0 : (c_ifid_write ? 1'b1 : vld_q[0]);
      vld_d[1] = (c_idex_bubble || !ifid_write_eff) ? 1'b0 : vld_q[0];
      vld_d[2] = c_exmem_flush ? 1'b0 : vld_q[1];
      vld_d[3] = vld_q[2];
    end

    // Halting as soon as the pipe will be empty, not one cycle later.
    if (flow) begin
      if (drain_mode) begin
        state_d = (vld_d == 4'b0000) ? ST_HALTED : ST_DRAIN;
      end else if (!mem_branch_taken && !lu && halt_req) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_RUN;
      end
    end

    if ((state_q == ST_RUN || state_q == ST_WAIT_MEM || state_q == ST_DRAIN) &&
        !c_pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      ret_drain_q   <= 1'b0;
      wait_cnt_q    <= '0;
      vld_q         <= 4'b0000;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_drain_q   <= ret_drain_d;
      wait_cnt_q    <= wait_cnt_d;
      vld_q         <= vld_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  // Outputs are forced low while reset is held, independent of the clock.
  assign pc_write     = !reset && c_pc_write;
  assign ifid_write   = !reset && c_ifid_write;
  assign ifid_flush   = !reset && c_ifid_flush;
  assign idex_bubble  = !reset && c_idex_bubble;
  assign exmem_flush  = !reset && c_exmem_flush;
  assign pipe_advance = !reset && c_pipe_advance;
  assign halted       = !reset && c_halted;
  assign mem_timeout  = !reset && mem_timeout_q;
  assign stall_cnt    = reset ? '0 : stall_cnt_q;
  assign dbg_state    = reset ? ST_RUN : state_q;
  assign dbg_vld      = reset ? 4'b0000 : vld_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4).
module tb_pipe_hazard_ctrl;
  import mips_pkg::*;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [5:0]       id_opcode;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             ex_memread, mem_branch_taken, mem_req, dmem_ready;
  logic             halt_req, resume;
  logic             pc_write, ifid_write, ifid_flush, idex_bubble;
  logic             exmem_flush, pipe_advance, halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [2:0]       dbg_state;
  logic [3:0]       dbg_vld;

  int pass_cnt = 0;
  int total    = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .id_opcode        (id_opcode),
    .id_rs            (id_rs),
    .id_rt            (id_rt),
    .ex_memread       (ex_memread),
    .ex_rt            (ex_rt),
    .mem_branch_taken (mem_branch_taken),
    .mem_req          (mem_req),
    .dmem_ready       (dmem_ready),
    .halt_req         (halt_req),
    .resume           (resume),
    .pc_write         (pc_write),
    .ifid_write       (ifid_write),
    .ifid_flush       (ifid_flush),
    .idex_bubble      (idex_bubble),
    .exmem_flush      (exmem_flush),
    .pipe_advance     (pipe_advance),
    .halted           (halted),
    .mem_timeout      (mem_timeout),
    .stall_cnt        (stall_cnt),
    .dbg_state        (dbg_state),
    .dbg_vld          (dbg_vld)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_opcode = OP_NOP; id_rs = 5'd0; id_rt = 5'd0;
    ex_memread = 1'b0; ex_rt = 5'd0; mem_branch_taken = 1'b0;
    mem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  int n;

  initial begin
    idle_inputs();
    reset = 1'b1;
    #3;
    // Reset: every output low even though RUN would otherwise advance.
    check("rst_pc_write", 32'(pc_write), 0);
    check("rst_pipe_adv", 32'(pipe_advance), 0);
    check("rst_stall", 32'(stall_cnt), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_timeout", 32'(mem_timeout), 0);
    tick();
    tick();
    reset = 1'b0;
    #2;
    check("idle_pc_write", 32'(pc_write), 1);
    check("idle_state", 32'(dbg_state), 32'(ST_RUN));
    check("idle_vld", 32'(dbg_vld), 0);

    // 1. load-use hazard and exclusions
    ex_memread = 1'b1; ex_rt = 5'd8; id_opcode = OP_RTYPE; id_rs = 5'd8; id_rt = 5'd3;
    #2;
    check("lu_pc_write", 32'(pc_write), 0);
    check("lu_ifid_write", 32'(ifid_write), 0);
    check("lu_bubble", 32'(idex_bubble), 1);
    check("lu_advance", 32'(pipe_advance), 1);
    tick();
    ex_rt = 5'd0;
    #2;
    check("lu_stall_cnt", 32'(stall_cnt), 1);
    check("lu_r0_pc_write", 32'(pc_write), 1);
    check("lu_r0_bubble", 32'(idex_bubble), 0);
    tick();
    ex_rt = 5'd8; id_opcode = OP_LW; id_rs = 5'd3; id_rt = 5'd8;
    #2;
    check("lu_lw_pc_write", 32'(pc_write), 1);
    check("lu_lw_bubble", 32'(idex_bubble), 0);
    id_opcode = OP_SW;
    #2;
    check("lu_sw_pc_write", 32'(pc_write), 0);
    ex_memread = 1'b0;
    tick();
    tick();
    check("vld_fill", 32'(dbg_vld), 32'h7);
    check("stall_after_lu", 32'(stall_cnt), 1);

    // 2. taken branch overrides load-use
    ex_memread = 1'b1; ex_rt = 5'd8; id_opcode = OP_RTYPE; id_rs = 5'd8; mem_branch_taken = 1'b1;
    #2;
    check("br_pc_write", 32'(pc_write), 1);
    check("br_ifid_flush", 32'(ifid_flush), 1);
    check("br_bubble", 32'(idex_bubble), 1);
    check("br_exmem_flush", 32'(exmem_flush), 1);
    check("br_advance", 32'(pipe_advance), 1);
    tick();
    idle_inputs();
    check("br_vld", 32'(dbg_vld), 32'h8);
    tick();

    // 3. memory wait: three not-ready cycles then ready
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      check("wait_freeze_adv", 32'(pipe_advance), 0);
      check("wait_freeze_pc", 32'(pc_write), 0);
      tick();
    end
    check("wait_state", 32'(dbg_state), 32'(ST_WAIT_MEM));
    check("wait_stall_cnt", 32'(stall_cnt), 4);
    dmem_ready = 1'b1;
    #2;
    check("wait_ready_adv", 32'(pipe_advance), 1);
    tick();
    idle_inputs();
    check("wait_back_run", 32'(dbg_state), 32'(ST_RUN));
    check("wait_vld", 32'(dbg_vld), 32'h3);

    // 5. drain and resume
    tick();
    tick();
    check("drain_full_vld", 32'(dbg_vld), 32'hF);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("drain_state", 32'(dbg_state), 32'(ST_DRAIN));
    n = 0;
    while (!halted && n < 8) begin
      #2;
      check("drain_no_pc", 32'(pc_write), 0);
      tick();
      n++;
    end
    check("drain_halted", 32'(halted), 1);
    check("drain_cycles", 32'(n), 4);
    check("drain_vld", 32'(dbg_vld), 0);
    check("drain_stall", 32'(stall_cnt), 8);
    #2;
    check("halt_pc", 32'(pc_write), 0);
    tick();
    check("halt_stall_hold", 32'(stall_cnt), 8);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    #2;
    check("resume_pc", 32'(pc_write), 1);
    check("resume_halted", 32'(halted), 0);

    // 6. async reset in the middle of WAIT_MEM
    mem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    #2;
    check("ar_state_wait", 32'(dbg_state), 32'(ST_WAIT_MEM));
    check("ar_stall_pre", 32'(stall_cnt), 9);
    reset = 1'b1;
    #1;
    check("ar_stall_zero", 32'(stall_cnt), 0);
    check("ar_state_out", 32'(dbg_state), 0);
    check("ar_vld_out", 32'(dbg_vld), 0);
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    check("ar_rel_state", 32'(dbg_state), 32'(ST_RUN));
    check("ar_rel_stall", 32'(stall_cnt), 0);
    check("ar_rel_pc", 32'(pc_write), 1);
    tick();

    // 4. timeout into ERROR, sticky until reset
    mem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check("to_pre_flag", 32'(mem_timeout), 0);
      check("to_pre_state", 32'(dbg_state), (i == 0) ? 32'(ST_RUN) : 32'(ST_WAIT_MEM));
      tick();
    end
    check("to_state_err", 32'(dbg_state), 32'(ST_ERROR));
    check("to_flag", 32'(mem_timeout), 1);
    mem_req = 1'b0; dmem_ready = 1'b1;
    tick();
    tick();
    check("to_sticky", 32'(mem_timeout), 1);
    check("to_frozen_pc", 32'(pc_write), 0);
    #2;
    reset = 1'b1;
    #1;
    check("to_reset_clear", 32'(mem_timeout), 0);
    reset = 1'b0;
    #1;
    check("to_reset_state", 32'(dbg_state), 32'(ST_RUN));

    // Final report
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the per-instruction control decoder that generates the wb/m/ex bundles.
- Decides every cycle whether the pipeline advances, stalls, bubbles or flushes: load-use hazards, taken branches resolved in MEM, and data-memory wait states.
- Provides a halt/drain/resume handshake for debug.
- Tracks per-stage valid bits and counts stall cycles.

Parameters:
TIMEOUT, 16, consecutive data-memory not-ready cycles that trigger ERROR (must be >= 2)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
id_opcode  in  6  opcode of the instruction in IF/ID
id_rs  in  5  rs field in IF/ID
id_rt  in  5  rt field in IF/ID
ex_memread  in  1  ID/EX instruction is a load
ex_rt  in  5  destination rt of the ID/EX instruction
mem_branch_taken  in  1  BEQ in EX/MEM resolved taken
mem_req  in  1  EX/MEM instruction accesses data memory this cycle
dmem_ready  in  1  data memory completes the access this cycle
halt_req  in  1  request drain and halt (level)
resume  in  1  leave HALTED (pulse)
pc_write  out  1  PC register enable
ifid_write  out  1  IF/ID enable
ifid_flush  out  1  load a bubble into IF/ID
idex_bubble  out  1  zero the wb/m/ex bundle entering ID/EX
exmem_flush  out  1  zero the control entering EX/MEM
pipe_advance  out  1  enable for ID/EX, EX/MEM, MEM/WB
halted  out  1  pipeline empty and stopped
mem_timeout  out  1  sticky, set on entering ERROR
stall_cnt  out  CNT_W  saturating count of cycles with pc_write=0 in RUN/WAIT_MEM/DRAIN

Behaviour:
- States: RUN, WAIT_MEM, DRAIN, HALTED, ERROR.
- Control outputs are combinational from state plus inputs; state, valid bits and counters are registered.
- Reset (asynchronous): state=RUN, vld[3:0]=0, stall_cnt=0, wait_cnt=0, mem_timeout=0. While reset is high, every output is 0.
- "Freeze": pc_write=ifid_write=pipe_advance=0, all flush/bubble outputs 0.
- Load-use hazard (lu) is asserted when all of these hold:
  - ex_memread=1 and ex_rt!=0;
  - ex_rt==id_rs, or ex_rt==id_rt with id_opcode in {RTYPE, SW, BEQ}. LW does not read rt.
- RUN, evaluated in priority order each cycle:
  1. mem_req&&!dmem_ready: freeze; next state WAIT_MEM; wait_cnt<=1.
  2. mem_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1, exmem_flush=1, pipe_advance=1. This overrides lu.
  3. lu: pc_write=0, ifid_write=0, idex_bubble=1, pipe_advance=1. Exactly one bubble per hazard cycle.
  4. Otherwise normal flow: pc_write=ifid_write=pipe_advance=1. If halt_req=1, the next state is DRAIN.
- WAIT_MEM:
  - dmem_ready=0: freeze. If wait_cnt==TIMEOUT-1, the next state is ERROR; otherwise wait_cnt++.
  - dmem_ready=1: this cycle behaves as RUN items 2-4, including halt_req sampling; next state is RUN.
- DRAIN:
  - Fetch stops: pc_write=0, ifid_flush=1, pipe_advance=1. The PC keeps the unfetched address.
  - Memory wait is honoured as in RUN, returning to DRAIN rather than RUN.
  - lu: ifid_write=0, ifid_flush=0, idex_bubble=1.
  - mem_branch_taken: pc_write=1 plus all three flushes, so resume fetches the target.
  - When vld==0 at a clock edge, the next state is HALTED.
- HALTED: freeze; halted=1. resume=1 gives next state RUN. halt_req is ignored outside RUN and WAIT_MEM-to-RUN.
- ERROR: freeze; mem_timeout=1. Only reset exits.
- Valid tracking: the IF stage is valid only in RUN. On each edge where pipe_advance=1:
  - vld[0] <= ifid_flush ? 0 : (ifid_write ? 1 : vld[0])
  - vld[1] <= (idex_bubble|!ifid_write_eff) ? 0 : vld[0], i.e. a bubble enters ID/EX whenever IF/ID holds
  - vld[2] <= exmem_flush ? 0 : vld[1]
  - vld[3] <= vld[2]
  - Freeze holds vld.
- stall_cnt: increments when pc_write=0 in RUN, WAIT_MEM or DRAIN; saturates at all-ones and never wraps.

Decomposition:
- Shared package mips_pkg:
  - opcode constants RTYPE=000000, LW=100011, SW=101011, BEQ=000100, NOP=100000;
  - state encoding (3-bit enum);
  - TIMEOUT and CNT_W defaults.
- Sub-module load_use_detect: purely combinational lu comparator with the reads-rt decode, reusable by the forwarding unit.

Test Plan:
1. Load-use hazard and its exclusions:
   - ex_memread=1, ex_rt=8, id_opcode=RTYPE, id_rs=8 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1.
   - Same stimulus with ex_rt=0 -> no stall.
   - id_opcode=LW, id_rt=8 -> no stall.
2. Branch beats load-use: mem_branch_taken=1 together with a lu condition -> pc_write=1, ifid_flush=idex_bubble=exmem_flush=1; vld[2:0]=0 next cycle.
3. Memory wait: mem_req=1, dmem_ready=0 for 3 cycles then 1 -> 3 freeze cycles, stall_cnt +3, pipe_advance=1 on the ready cycle, state back to RUN.
4. Timeout: TIMEOUT=4, dmem_ready held 0 -> ERROR entered after the 4th not-ready cycle, mem_timeout=1 and stays 1; async reset clears it.
5. Drain and resume: halt_req with vld=1111 -> halted=1 within 5 cycles, PC never written. resume pulse -> pc_write=1 the following cycle.
6. Async reset mid-WAIT_MEM -> all outputs 0 immediately, without waiting for a clock edge; after release state=RUN, vld=0, stall_cnt=0.
